// File: rtl/nand_nor_complement_bist_if.sv
// Stimulus/response bundle between the BIST engine and the NAND/NOR/complement
// logic unit: master is the BIST side, slave is the controlling/unit side.
interface nand_nor_complement_bist_if #(
    parameter int ERR_W = 11
);
    logic             start;
    logic [3:0]       dut_A;
    logic [3:0]       dut_B;
    logic [1:0]       dut_Sel;
    logic [3:0]       dut_Out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] error_count;
    logic             fail_valid;
    logic [9:0]       fail_vec;

    modport master (
        input  start, dut_Out,
        output dut_A, dut_B, dut_Sel, busy, done, pass, error_count, fail_valid, fail_vec
    );

    modport slave (
        output start, dut_Out,
        input  dut_A, dut_B, dut_Sel, busy, done, pass, error_count, fail_valid, fail_vec
    );
endinterface

// File: rtl/nand_nor_complement_bist.sv
// Exhaustive {Sel,A,B} sweep BIST for the NAND/NOR/complement unit.
// Optional early stop on first mismatch: NAND_NOR_COMPLEMENT_BIST_STOP_ON_FAIL_EN.
module nand_nor_complement_bist #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 11
) (
    input  logic clk,
    input  logic rst,
    nand_nor_complement_bist_if.master bus
);

`ifdef NAND_NOR_COMPLEMENT_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [3:0] LAST_HOLD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [9:0]       vec;
    logic [3:0]       hold;
    logic [ERR_W-1:0] err;
    logic [ERR_W-1:0] err_next;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail_valid;
    logic [9:0]       fail_vec;
    logic             mismatch;
    logic             last_hold;

    function automatic logic [3:0] golden(input logic [9:0] v);
        logic [1:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        sel = v[9:8];
        a   = v[7:4];
        b   = v[3:0];
        case (sel)
            2'b00:   golden = ~(a & b);
            2'b01:   golden = ~(a | b);
            2'b10:   golden = ~a;
            default: golden = ~b;
        endcase
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] e);
        sat_inc = (e == {ERR_W{1'b1}}) ? e : e + 1'b1;
    endfunction

    always_comb begin
        mismatch  = (bus.dut_Out != golden(vec));
        last_hold = (hold == LAST_HOLD);
        err_next  = mismatch ? sat_inc(err) : err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= '0;
            hold       <= '0;
            err        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state      <= RUN;
                        vec        <= '0;
                        hold       <= '0;
                        err        <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                    end
                end
                RUN: begin
                    // Compare only once the vector has settled for its full hold time.
                    if (last_hold) begin
                        err <= err_next;
                        if (mismatch && !fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= vec;
                        end
                        if (vec == 10'h3FF || (STOP_ON_FAIL && mismatch)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            vec  <= vec + 10'd1;
                            hold <= '0;
                        end
                    end else begin
                        hold <= hold + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_Sel     = vec[9:8];
    assign bus.dut_A       = vec[7:4];
    assign bus.dut_B       = vec[3:0];
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.pass        = pass;
    assign bus.error_count = err;
    assign bus.fail_valid  = fail_valid;
    assign bus.fail_vec    = fail_vec;

endmodule

// File: tb/tb_nand_nor_complement_bist.sv
// Bench for nand_nor_complement_bist: two instances (SETTLE 1 / ERR_W 11 and
// SETTLE 2 / ERR_W 4) sweep a logic-unit model carrying table-driven faults.
module tb_nand_nor_complement_bist;

    logic clk = 1'b0;
    logic rst;
    logic start;

    always #5 clk = ~clk;

    nand_nor_complement_bist_if #(.ERR_W(11)) bus1 ();
    nand_nor_complement_bist_if #(.ERR_W(4))  bus2 ();

    nand_nor_complement_bist #(.SETTLE_CYCLES(1), .ERR_W(11)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    nand_nor_complement_bist #(.SETTLE_CYCLES(2), .ERR_W(4)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    // Per-vector corruption of the logic unit's result; zero means healthy.
    logic [3:0] flip [1024];

    function automatic logic [3:0] ref_out(input logic [1:0] sel, input logic [3:0] a,
                                           input logic [3:0] b);
        case (sel)
            2'd0:    return ~(a & b);
            2'd1:    return ~(a | b);
            2'd2:    return ~a;
            default: return ~b;
        endcase
    endfunction

    assign bus1.start   = start;
    assign bus2.start   = start;
    assign bus1.dut_Out = ref_out(bus1.dut_Sel, bus1.dut_A, bus1.dut_B)
                          ^ flip[{bus1.dut_Sel, bus1.dut_A, bus1.dut_B}];
    assign bus2.dut_Out = ref_out(bus2.dut_Sel, bus2.dut_A, bus2.dut_B)
                          ^ flip[{bus2.dut_Sel, bus2.dut_A, bus2.dut_B}];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic set_healthy();
        for (int i = 0; i < 1024; i++) flip[i] = 4'h0;
    endtask

    task automatic set_stuck_out0();
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] v;
            v = 10'(i);
            flip[i] = {3'b000, ref_out(v[9:8], v[7:4], v[3:0]) & 4'h1};
        end
    endtask

    task automatic set_sel11_nota();
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] v;
            v = 10'(i);
            flip[i] = (v[9:8] == 2'b11) ? (~v[7:4]) ^ (~v[3:0]) : 4'h0;
        end
    endtask

    task automatic set_random(input int density);
        for (int i = 0; i < 1024; i++)
            flip[i] = ($urandom_range(0, density - 1) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy1"}, 32'(bus1.busy), 0);
        check({tag, "_done1"}, 32'(bus1.done), 0);
        check({tag, "_pass1"}, 32'(bus1.pass), 0);
        check({tag, "_err1"},  32'(bus1.error_count), 0);
        check({tag, "_fv1"},   32'(bus1.fail_valid), 0);
        check({tag, "_fvec1"}, 32'(bus1.fail_vec), 0);
        check({tag, "_vec1"},  32'({bus1.dut_Sel, bus1.dut_A, bus1.dut_B}), 0);
        check({tag, "_busy2"}, 32'(bus2.busy), 0);
        check({tag, "_done2"}, 32'(bus2.done), 0);
        check({tag, "_err2"},  32'(bus2.error_count), 0);
        check({tag, "_fv2"},   32'(bus2.fail_valid), 0);
        check({tag, "_vec2"},  32'({bus2.dut_Sel, bus2.dut_A, bus2.dut_B}), 0);
    endtask

    // Launch one sweep on both instances and score it against the fault table.
    task automatic run_sweep(input string tag, output int cnt_out, output int first_out);
        int cnt, first, nvec, d1, d2, exp_err1, exp_err2, stop_en;
        int busy1, busy2, done_at1, done_at2;
        cnt   = 0;
        first = -1;
        for (int i = 0; i < 1024; i++)
            if (flip[i] != 4'h0) begin
                cnt++;
                if (first < 0) first = i;
            end
`ifdef NAND_NOR_COMPLEMENT_BIST_STOP_ON_FAIL_EN
        stop_en = 1;
`else
        stop_en = 0;
`endif
        nvec     = (stop_en != 0 && first >= 0) ? first + 1 : 1024;
        exp_err1 = (stop_en != 0) ? ((cnt > 0) ? 1 : 0) : ((cnt > 2047) ? 2047 : cnt);
        exp_err2 = (stop_en != 0) ? ((cnt > 0) ? 1 : 0) : ((cnt > 15) ? 15 : cnt);
        d1 = nvec;
        d2 = nvec * 2;
        busy1 = 0;
        busy2 = 0;
        done_at1 = -1;
        done_at2 = -1;

        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k <= 2052; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus1.busy) busy1++;
            if (bus2.busy) busy2++;
            if (bus1.done && done_at1 < 0) done_at1 = k;
            if (bus2.done && done_at2 < 0) done_at2 = k;
            if (k < d1)
                check({tag, "_seq1"}, 32'({bus1.dut_Sel, bus1.dut_A, bus1.dut_B}), 32'(k));
            if (k < d2)
                check({tag, "_seq2"}, 32'({bus2.dut_Sel, bus2.dut_A, bus2.dut_B}), 32'(k / 2));
            // Mid-sweep pulses and one landing on instance 1's final compare edge.
            if ((k == 10 || k == 500) && k < d1 - 1) start = 1'b1;
            if (k == d1 - 1) start = 1'b1;
        end

        check({tag, "_busylen1"}, 32'(busy1), 32'(d1));
        check({tag, "_busylen2"}, 32'(busy2), 32'(d2));
        check({tag, "_doneat1"},  32'(done_at1), 32'(d1));
        check({tag, "_doneat2"},  32'(done_at2), 32'(d2));
        check({tag, "_done1"},    32'(bus1.done), 1);
        check({tag, "_done2"},    32'(bus2.done), 1);
        check({tag, "_busy1"},    32'(bus1.busy), 0);
        check({tag, "_pass1"},    32'(bus1.pass), (cnt == 0) ? 1 : 0);
        check({tag, "_pass2"},    32'(bus2.pass), (cnt == 0) ? 1 : 0);
        check({tag, "_err1"},     32'(bus1.error_count), 32'(exp_err1));
        check({tag, "_err2"},     32'(bus2.error_count), 32'(exp_err2));
        check({tag, "_fv1"},      32'(bus1.fail_valid), (cnt > 0) ? 1 : 0);
        check({tag, "_fv2"},      32'(bus2.fail_valid), (cnt > 0) ? 1 : 0);
        check({tag, "_fvec1"},    32'(bus1.fail_vec), (first >= 0) ? 32'(first) : 0);
        check({tag, "_fvec2"},    32'(bus2.fail_vec), (first >= 0) ? 32'(first) : 0);
        check({tag, "_last1"},    32'({bus1.dut_Sel, bus1.dut_A, bus1.dut_B}), 32'(nvec - 1));
        check({tag, "_last2"},    32'({bus2.dut_Sel, bus2.dut_A, bus2.dut_B}), 32'(nvec - 1));
        cnt_out   = cnt;
        first_out = first;
    endtask

    initial begin
        int cnt, first;
        rst   = 1'b1;
        start = 1'b0;
        set_healthy();
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("idle");

        set_healthy();
        run_sweep("healthy", cnt, first);

        set_stuck_out0();
        run_sweep("stuck0", cnt, first);
`ifndef NAND_NOR_COMPLEMENT_BIST_STOP_ON_FAIL_EN
        check("stuck0_err_abs",  32'(bus1.error_count), 512);
        check("stuck0_sat_abs",  32'(bus2.error_count), 15);
`else
        check("stuck0_err_abs",  32'(bus1.error_count), 1);
`endif
        check("stuck0_fvec_abs", 32'(bus1.fail_vec), 32'h000);

        set_sel11_nota();
        run_sweep("sel11", cnt, first);
`ifndef NAND_NOR_COMPLEMENT_BIST_STOP_ON_FAIL_EN
        check("sel11_err_abs",  32'(bus1.error_count), 240);
`endif
        check("sel11_fvec_abs", 32'(bus1.fail_vec), 32'h301);

        for (int r = 0; r < 3; r++) begin
            set_random((r == 0) ? 128 : 32);
            run_sweep($sformatf("rand%0d", r), cnt, first);
        end

        // Abort a sweep with reset, then confirm a clean restart.
        set_healthy();
        @(negedge clk);
        start = 1'b1;
        repeat (300) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_abort_busy", 32'(bus1.busy), 1);
        rst = 1'b1;
        #1;
        check_reset_values("abort");
        repeat (3) @(negedge clk);
        check_reset_values("abort_hold");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_resume", 32'(bus1.busy), 0);
        check("abort_no_resume2", 32'(bus2.busy), 0);
        run_sweep("fresh", cnt, first);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
